// File: rtl/inst_fetch_buffer_if.sv
// inst_fetch_buffer_if: bundles the fetch-side push bus, the decode-side pop
// bus and the status flags of the instruction fetch buffer.
// master = fetch/decode side, slave = the buffer itself.
interface inst_fetch_buffer_if;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [1:0]  in_mask;
    logic [63:0] in_inst;
    logic [1:0]  pop;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0;
    logic [31:0] out_inst0;
    logic [31:0] out_pc1;
    logic [31:0] out_inst1;
    logic        stall_req;
    logic        overflow;

    modport master (
        output flush, in_valid, in_pc, in_mask, in_inst, pop,
        input  out_valid, out_pc0, out_inst0, out_pc1, out_inst1, stall_req, overflow
    );

    modport slave (
        input  flush, in_valid, in_pc, in_mask, in_inst, pop,
        output out_valid, out_pc0, out_inst0, out_pc1, out_inst1, stall_req, overflow
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: decoupling queue between fetch and decode.
// Takes 64-bit fetch packets (two slots, masked), compacts the valid slots
// into a circular array of {pc, inst}, and presents up to two in-order
// instructions per cycle. Stall is raised from the registered count only.
// Optional macro IBUF_BYPASS_EN: when the buffer holds fewer than two
// entries, the compacted input slots are forwarded combinationally to the
// outputs in the same cycle; entries popped that way are never written.
module inst_fetch_buffer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned HEADROOM = 4
) (
    input logic                 clk,
    input logic                 reset,
    inst_fetch_buffer_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   ext_t;

    localparam ext_t DEPTH_E    = ext_t'(DEPTH);
    localparam ext_t HEADROOM_E = ext_t'(HEADROOM);

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    ptr_t rd_ptr;
    ptr_t wr_ptr;
    cnt_t count;
    logic overflow_q;

    logic        push_en;
    logic [1:0]  n_in;
    logic [1:0]  n_req;
    logic [1:0]  n_stored;
    logic [1:0]  n_vis;
    logic [1:0]  n_pop;
    logic [1:0]  n_skip;
    logic [1:0]  n_rd;
    logic [1:0]  n_wr;
    logic [31:0] a_pc, a_inst, b_pc, b_inst;
    logic [31:0] w0_pc, w0_inst;
    logic        accept;
    logic        drop;
    ext_t        free_e;
    ext_t        space;
    ptr_t        rd_ptr1;
    ptr_t        wr_ptr1;

    // Compact the input packet: slot a is the first valid slot, slot b is
    // slot 1 when both slots are valid.
    always_comb begin
        push_en = bus.in_valid & ~bus.flush;
        n_in    = {1'b0, bus.in_mask[0]} + {1'b0, bus.in_mask[1]};
        b_pc    = bus.in_pc + 32'd4;
        b_inst  = bus.in_inst[63:32];
        if (bus.in_mask[0]) begin
            a_pc   = bus.in_pc;
            a_inst = bus.in_inst[31:0];
        end else begin
            a_pc   = b_pc;
            a_inst = b_inst;
        end
        unique case (bus.pop)
            2'b01:   n_req = 2'd1;
            2'b11:   n_req = 2'd2;
            default: n_req = 2'd0;
        endcase
    end

    // Present head and head+1; optionally forward input slots when the
    // stored entries do not fill both output positions.
    always_comb begin
        rd_ptr1       = rd_ptr + ptr_t'(1);
        n_stored      = (count >= cnt_t'(2)) ? 2'd2 : count[1:0];
        bus.out_valid = {count >= cnt_t'(2), count != '0};
        bus.out_pc0   = pc_mem[rd_ptr];
        bus.out_inst0 = inst_mem[rd_ptr];
        bus.out_pc1   = pc_mem[rd_ptr1];
        bus.out_inst1 = inst_mem[rd_ptr1];
`ifdef IBUF_BYPASS_EN
        if (push_en && count == '0) begin
            bus.out_valid = (n_in == 2'd2) ? 2'b11 : ((n_in == 2'd1) ? 2'b01 : 2'b00);
            bus.out_pc0   = a_pc;
            bus.out_inst0 = a_inst;
            bus.out_pc1   = b_pc;
            bus.out_inst1 = b_inst;
        end else if (push_en && count == cnt_t'(1) && n_in != 2'd0) begin
            bus.out_valid = 2'b11;
            bus.out_pc1   = a_pc;
            bus.out_inst1 = a_inst;
        end
`endif
        n_vis = bus.out_valid[1] ? 2'd2 : {1'b0, bus.out_valid[0]};
    end

    // Pop clamp, capacity check (pop applied first) and write selection.
    // Entries consumed straight from the input (n_skip) are neither written
    // nor read from the array; without bypass n_skip is always zero.
    always_comb begin
        n_pop   = (n_req > n_vis) ? n_vis : n_req;
        n_skip  = (n_pop > n_stored) ? (n_pop - n_stored) : 2'd0;
        n_rd    = n_pop - n_skip;
        free_e  = DEPTH_E - ext_t'(count);
        space   = free_e + ext_t'(n_pop);
        accept  = push_en && (ext_t'(n_in) <= space);
        drop    = push_en && !accept;
        n_wr    = accept ? (n_in - n_skip) : 2'd0;
        wr_ptr1 = wr_ptr + ptr_t'(1);
        if (n_skip == 2'd0) begin
            w0_pc   = a_pc;
            w0_inst = a_inst;
        end else begin
            w0_pc   = b_pc;
            w0_inst = b_inst;
        end
        bus.stall_req = free_e < HEADROOM_E;
        bus.overflow  = overflow_q;
    end

    // Pointer, count and sticky overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + ptr_t'(n_rd);
                wr_ptr <= wr_ptr + ptr_t'(n_wr);
                count  <= count + cnt_t'(n_wr) - cnt_t'(n_rd);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Data array writes (not reset).
    always_ff @(posedge clk) begin
        if (n_wr != 2'd0) begin
            pc_mem[wr_ptr]   <= w0_pc;
            inst_mem[wr_ptr] <= w0_inst;
        end
        if (n_wr == 2'd2) begin
            pc_mem[wr_ptr1]   <= b_pc;
            inst_mem[wr_ptr1] <= b_inst;
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed stimulus with a scoreboard queue of
// expected {pc, inst} entries; a negedge monitor compares visible outputs
// against the queue head and retires entries as decode consumes them.
module tb_inst_fetch_buffer;
    logic clk = 1'b0;
    logic reset;

    inst_fetch_buffer_if ifc ();

    inst_fetch_buffer #(.DEPTH(16), .HEADROOM(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t sbq[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   exp_count = 0;
    logic exp_ovf   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int clamp_pop(input logic [1:0] p, input int c);
        int r;
        r = (p == 2'b11) ? 2 : ((p == 2'b01) ? 1 : 0);
        if (r > c) r = c;
        return r;
    endfunction

    // Monitor: compare visible entries with the scoreboard, retire consumed ones.
    always @(negedge clk) begin
        if (reset || ifc.flush) begin
            sbq.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (exp_count > i) begin
                    if (sbq.size() <= i) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_underrun: slot %0d visible, got none, want entry", i);
                    end else if (i == 0) begin
                        chk("out0", {ifc.out_pc0, ifc.out_inst0}, sbq[0]);
                    end else begin
                        chk("out1", {ifc.out_pc1, ifc.out_inst1}, sbq[1]);
                    end
                end
            end
            for (int k = 0; k < clamp_pop(ifc.pop, exp_count); k++) begin
                if (sbq.size() > 0) void'(sbq.pop_front());
            end
        end
    end

    // One clock of stimulus; acc is the hand-decided accept/drop outcome.
    task automatic cyc(input logic fl, input logic v, input logic [31:0] pc,
                       input logic [1:0] m, input logic [63:0] ins,
                       input logic [1:0] p, input logic acc);
        int nxt;
        ifc.flush    = fl;
        ifc.in_valid = v;
        ifc.in_pc    = pc;
        ifc.in_mask  = m;
        ifc.in_inst  = ins;
        ifc.pop      = p;
        if (fl) begin
            nxt = 0;
        end else begin
            nxt = exp_count - clamp_pop(p, exp_count);
            if (v && acc) begin
                nxt += int'(m[0]) + int'(m[1]);
                if (m[0]) sbq.push_back(ent_t'({pc, ins[31:0]}));
                if (m[1]) sbq.push_back(ent_t'({pc + 32'd4, ins[63:32]}));
            end
            if (v && !acc) exp_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_count    = nxt;
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.pop      = 2'b00;
        chk("out_valid", 64'(ifc.out_valid), 64'({exp_count >= 2, exp_count >= 1}));
        chk("stall_req", 64'(ifc.stall_req), 64'((16 - exp_count) < 4));
        chk("overflow", 64'(ifc.overflow), 64'(exp_ovf));
    endtask

    task automatic push2(input logic [31:0] pc, input logic [1:0] p, input logic acc);
        cyc(1'b0, 1'b1, pc, 2'b11, {~(pc + 32'd4), ~pc}, p, acc);
    endtask

    task automatic drain();
        while (exp_count > 0) cyc(1'b0, 1'b0, 32'd0, 2'b00, 64'd0, 2'b11, 1'b1);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        reset        = 1'b1;
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_pc    = '0;
        ifc.in_mask  = '0;
        ifc.in_inst  = '0;
        ifc.pop      = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_stall", 64'(ifc.stall_req), 64'd0);
        chk("rst_overflow", 64'(ifc.overflow), 64'd0);

        // Full packet, visible next cycle
        cyc(1'b0, 1'b1, 32'hBFC0_0000, 2'b11, {32'h2402_0002, 32'h2401_0001}, 2'b00, 1'b1);
        chk("t1_valid", 64'(ifc.out_valid), 64'd3);
        chk("t1_pc0", 64'(ifc.out_pc0), 64'hBFC0_0000);
        chk("t1_inst0", 64'(ifc.out_inst0), 64'h2401_0001);
        chk("t1_pc1", 64'(ifc.out_pc1), 64'hBFC0_0004);
        chk("t1_inst1", 64'(ifc.out_inst1), 64'h2402_0002);
        drain();

        // Mask 10: only slot 1 stored at pc+4
        cyc(1'b0, 1'b1, 32'hBFC0_0010, 2'b10, {32'h1111_2222, 32'h3333_4444}, 2'b00, 1'b1);
        chk("t2_valid", 64'(ifc.out_valid), 64'd1);
        chk("t2_pc0", 64'(ifc.out_pc0), 64'hBFC0_0014);
        chk("t2_inst0", 64'(ifc.out_inst0), 64'h1111_2222);
        drain();

        // Fill to 14 -> stall, 15, drop at 15, accept with pop at 15
        for (int i = 0; i < 7; i++) begin
            push2(32'h0000_1000 + 32'(8 * i), 2'b00, 1'b1);
            if (i == 5) chk("t3_stall_at12", 64'(ifc.stall_req), 64'd0);
            if (i == 6) chk("t3_stall_at14", 64'(ifc.stall_req), 64'd1);
        end
        cyc(1'b0, 1'b1, 32'h0000_1038, 2'b01, {32'hDEAD_0001, 32'hDEAD_0000}, 2'b00, 1'b1);
        push2(32'h0000_1040, 2'b00, 1'b0);
        chk("t3_drop_overflow", 64'(ifc.overflow), 64'd1);
        push2(32'h0000_1048, 2'b11, 1'b1);
        chk("t3_full_stall", 64'(ifc.stall_req), 64'd1);
        repeat (5) cyc(1'b0, 1'b0, 32'd0, 2'b00, 64'd0, 2'b11, 1'b1);
        chk("t3_count5_valid", 64'(ifc.out_valid), 64'd3);
        chk("t3_count5_stall", 64'(ifc.stall_req), 64'd0);

        // Flush with simultaneous push and pop
        cyc(1'b1, 1'b1, 32'h0000_2000, 2'b11, 64'h0123_4567_89AB_CDEF, 2'b11, 1'b1);
        chk("t4_valid", 64'(ifc.out_valid), 64'd0);
        chk("t4_stall", 64'(ifc.stall_req), 64'd0);
        chk("t4_overflow_kept", 64'(ifc.overflow), 64'd1);

        // Steady push/pop across the pointer wrap
        for (int i = 0; i < 20; i++) push2(32'h0000_3000 + 32'(8 * i), 2'b11, 1'b1);
        drain();
        chk("t5_sb_empty", 64'(sbq.size()), 64'd0);

        // Asynchronous reset between edges at count 6
        for (int i = 0; i < 3; i++) push2(32'h0000_4000 + 32'(8 * i), 2'b00, 1'b1);
        chk("t6_pre_valid", 64'(ifc.out_valid), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(ifc.out_valid), 64'd0);
        chk("t6_rst_stall", 64'(ifc.stall_req), 64'd0);
        chk("t6_rst_overflow", 64'(ifc.overflow), 64'd0);
        exp_count = 0;
        exp_ovf   = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        cyc(1'b0, 1'b1, 32'h0000_5000, 2'b11, {32'hCAFE_0001, 32'hCAFE_0000}, 2'b00, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
